// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM state type and constants for the instruction fetch unit
package ifu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} ifu_state_e;
  localparam int PC_INC = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: synchronous FIFO with push/pop/clear, clear overriding push and pop
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push_w, pop_w;
  // pointer and occupancy next state; clear empties the buffer outright
  always_comb begin
    pop_w  = pop_i && !empty_o;
    push_w = push_i && (!full_o || pop_w);
    wr_d   = clear_i ? '0 : wr_q + PW'(push_w);
    rd_d   = clear_i ? '0 : rd_q + PW'(pop_w);
    cnt_d  = clear_i ? '0 : cnt_q + CW'(push_w) - CW'(pop_w);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage array needs no reset: entries are only visible once counted
  always_ff @(posedge clk_i) begin
    if (push_w && !clear_i) mem_q[wr_q] <= wdata_i;
  end
  assign rdata_o = mem_q[rd_q];
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, imem req/gnt/rvalid fetch FSM and decoder-side buffer; IFU_PERF_CNT_EN adds fetch/flush counters
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [DATA_W-1:0] imem_rdata_i,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  output logic              instr_valid_o,
  input  logic              instr_ready_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  ifu_state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, target;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [CW-1:0] fifo_cnt;
  logic fifo_full, fifo_empty, push, pop, full_after;
  assign target     = branch_target_i & ~ADDR_W'(3);
  assign pop        = !fifo_empty && instr_ready_i;
  assign full_after = fifo_cnt == CW'(FIFO_DEPTH - 1) && !pop;
  // state and pc registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  // next state: a redirect during a granted or in-flight fetch waits out the response in FLUSH
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = (branch_i || !fifo_full) ? REQ : IDLE;
      REQ:   state_d = imem_gnt_i ? (branch_i ? FLUSH : WAIT) : REQ;
      WAIT:  state_d = imem_rvalid_i ? ((branch_i || !full_after) ? REQ : IDLE)
                                     : (branch_i ? FLUSH : WAIT);
      FLUSH: state_d = imem_rvalid_i ? REQ : FLUSH;
    endcase
    pc_d = branch_i ? target : (state_q == REQ && imem_gnt_i) ? pc_q + ADDR_W'(PC_INC) : pc_q;
    push = state_q == WAIT && imem_rvalid_i && !branch_i;
  end
  // outputs: the request address is the live pc; buffer outputs read zero when empty
  always_comb begin
    imem_req_o    = state_q == REQ;
    imem_addr_o   = pc_q;
    instr_valid_o = !fifo_empty;
    instr_o       = fifo_empty ? '0 : head[DATA_W-1:0];
    instr_pc_o    = fifo_empty ? '0 : head[ADDR_W+DATA_W-1:DATA_W];
  end
  ifu_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (branch_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({pc_q - ADDR_W'(PC_INC), imem_rdata_i}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .cnt_o   (fifo_cnt)
  );
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;
  // count buffered instructions and redirect pulses
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_q + 32'(push);
      flush_cnt_q <= flush_cnt_q + 32'(branch_i);
    end
  end
  assign fetch_cnt_o = fetch_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif
endmodule
